// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I width codes,
// FSM state encoding and byte-lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } lsu_state_e;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Byte lane `lane` is covered by an access at offset `off` (byte or half).
    function automatic logic lane_hit(input logic [1:0] off, input logic half,
                                      input logic [1:0] lane);
        return half ? (lane[1] == off[1]) : (lane == off);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load lane extract with sign/zero extension,
// and store lane merge into a previously read word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ld_word_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    output logic [XLEN-1:0] ld_data_o,
    input  logic [XLEN-1:0] st_word_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [1:0]      st_off_i,
    input  logic            st_half_i,
    output logic [XLEN-1:0] st_merged_o
);

    logic [7:0]  ld_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign ld_lane[gi] = ld_word_i[8*gi +: 8];
        // Halfword stores place data[15:8] in the upper lane of the pair.
        assign st_merged_o[8*gi +: 8] =
            lane_hit(st_off_i, st_half_i, 2'(gi))
                ? (st_half_i ? st_data_i[8*(gi%2) +: 8] : st_data_i[7:0])
                : st_word_i[8*gi +: 8];
    end

    always_comb begin
        ld_byte = ld_lane[ld_off_i];
        ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_H:    ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
            F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte/half access on a word-only data memory,
// SB/SH via a two-cycle read-modify-write, and alignment/funct3 fault tracking.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_load,
    input  logic                   req_store,
    input  logic [2:0]             req_funct3,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   lsu_stall,
    output logic                   lsu_done,
    output logic [XLEN-1:0]        lsu_rdata,
    output logic                   lsu_fault,
    output logic [XLEN-1:0]        fault_addr,
    output logic [FAULT_CNT_W-1:0] fault_count,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [XLEN-1:0]        dmem_wdata,
    output logic                   dmem_read,
    output logic                   dmem_write,
    input  logic [XLEN-1:0]        dmem_rdata
);

    lsu_state_e             state_q, state_d, phase;
    logic [XLEN-1:0]        hold_addr_q, hold_wdata_q, hold_word_q;
    logic [2:0]             hold_funct3_q;
    logic [XLEN-1:0]        fault_addr_q;
    logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;

    logic f3_ok, kind_ok, misaligned, req_bad, req_take, fault_evt, rmw_start;
    logic [XLEN-1:0] ld_data, st_merged;

    lsu_align #(.XLEN(XLEN)) u_align (
        .ld_word_i   (dmem_rdata),
        .ld_funct3_i (req_funct3),
        .ld_off_i    (req_addr[1:0]),
        .ld_data_o   (ld_data),
        .st_word_i   (hold_word_q),
        .st_data_i   (hold_wdata_q),
        .st_off_i    (hold_addr_q[1:0]),
        .st_half_i   (is_half(hold_funct3_q)),
        .st_merged_o (st_merged)
    );

    always_comb begin
        kind_ok    = req_load ^ req_store;
        f3_ok      = req_load ? (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                              : (req_funct3 inside {F3_B, F3_H, F3_W});
        misaligned = ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) ||
                     (is_half(req_funct3) && req_addr[0]);
        req_bad    = !kind_ok || !f3_ok || misaligned;
        req_take   = !reset && req_valid && (state_q == IDLE);
        fault_evt  = req_take && req_bad;
        rmw_start  = req_take && !req_bad && req_store && (req_funct3 != F3_W);
        // Memory read is async, so the read phase of an RMW overlaps the accepting cycle.
        phase      = rmw_start ? RMW_RD : state_q;
        fault_count_d = (&fault_count_q) ? fault_count_q : fault_count_q + 1'b1;
    end

    always_comb begin
        state_d    = IDLE;
        lsu_stall  = 1'b0;
        lsu_done   = 1'b0;
        lsu_fault  = 1'b0;
        lsu_rdata  = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        if (!reset) begin
            case (phase)
                RMW_RD: begin
                    state_d   = RMW_WR;
                    lsu_stall = 1'b1;
                    dmem_read = 1'b1;
                    dmem_addr = {req_addr[XLEN-1:2], 2'b00};
                end
                RMW_WR: begin
                    dmem_write = 1'b1;
                    dmem_addr  = {hold_addr_q[XLEN-1:2], 2'b00};
                    dmem_wdata = st_merged;
                    lsu_done   = 1'b1;
                end
                default: begin
                    if (req_take) begin
                        lsu_done = 1'b1;
                        if (req_bad) begin
                            lsu_fault = 1'b1;
                        end else if (req_load) begin
                            dmem_read = 1'b1;
                            dmem_addr = {req_addr[XLEN-1:2], 2'b00};
                            lsu_rdata = ld_data;
                        end else begin
                            dmem_write = 1'b1;
                            dmem_addr  = {req_addr[XLEN-1:2], 2'b00};
                            dmem_wdata = req_wdata;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            hold_word_q   <= '0;
            hold_funct3_q <= '0;
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (phase == RMW_RD) begin
                hold_addr_q   <= req_addr;
                hold_wdata_q  <= req_wdata;
                hold_word_q   <= dmem_rdata;
                hold_funct3_q <= req_funct3;
            end
            if (fault_evt) begin
                fault_addr_q  <= req_addr;
                fault_count_q <= fault_count_d;
            end
        end
    end

    assign fault_addr  = fault_addr_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu against a word memory model with async read.
module tb_mem_stage_lsu;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        lsu_stall, lsu_done, lsu_fault, dmem_read, dmem_write;
    logic [31:0] lsu_rdata, fault_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  fault_count;

    logic [31:0] mem [0:255];
    int          wr_count = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign dmem_rdata = dmem_read ? mem[dmem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (dmem_write) begin
            mem[dmem_addr[9:2]] <= dmem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    mem_stage_lsu #(.XLEN(32), .FAULT_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_fault(lsu_fault), .fault_addr(fault_addr), .fault_count(fault_count),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_rdata(dmem_rdata)
    );

    task automatic drive(input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_valid = v; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, W, 32'h100, 32'h0);
        @(negedge clk);
        $display("txn reset-with-LW done=%0b read=%0b cnt=%0d", lsu_done, dmem_read, fault_count);
        checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", lsu_done); end
        checks++; if (dmem_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", dmem_read); end
        checks++; if (lsu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", lsu_stall); end
        checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", lsu_rdata); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (fault_count !== 8'h0) begin failures++; $display("FAIL reset_fcount got=%h exp=00", fault_count); end
        checks++; if (fault_addr !== 32'h0) begin failures++; $display("FAIL reset_faddr got=%h exp=0", fault_addr); end
    endtask

    task automatic test_store_word();
        drive(1'b1, 1'b0, 1'b1, W, 32'h100, 32'h8899AABB);
        @(negedge clk);
        $display("txn SW addr=%h wdata=%h write=%0b", dmem_addr, dmem_wdata, dmem_write);
        checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0) begin failures++; $display("FAIL sw_strobe got wr=%b rd=%b exp wr=1 rd=0", dmem_write, dmem_read); end
        checks++; if (dmem_wdata !== 32'h8899AABB) begin failures++; $display("FAIL sw_wdata got=%h exp=8899aabb", dmem_wdata); end
        checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", dmem_addr); end
        checks++; if (lsu_done !== 1'b1 || lsu_stall !== 1'b0) begin failures++; $display("FAIL sw_handshake got done=%b stall=%b exp done=1 stall=0", lsu_done, lsu_stall); end
        drive(1'b0, 1'b0, 1'b0, B, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (mem[8'h40] !== 32'h8899AABB) begin failures++; $display("FAIL sw_mem got=%h exp=8899aabb", mem[8'h40]); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{B, BU, H, HU, W};
        logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
            @(negedge clk);
            $display("txn LOAD f3=%b addr=%h rdata=%h", f3s[i], adrs[i], lsu_rdata);
            checks++; if (lsu_rdata !== exps[i]) begin failures++; $display("FAIL load_rdata[%0d] got=%h exp=%h", i, lsu_rdata, exps[i]); end
            checks++; if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || dmem_read !== 1'b1 || lsu_fault !== 1'b0)
                begin failures++; $display("FAIL load_ctrl[%0d] got done=%b stall=%b rd=%b flt=%b exp 1 0 1 0", i, lsu_done, lsu_stall, dmem_read, lsu_fault); end
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s  [2] = '{B, H};
        logic [31:0] adrs [2] = '{32'h102, 32'h100};
        logic [31:0] wds  [2] = '{32'hDEADBE11, 32'hFFFF1234};
        logic [31:0] exps [2] = '{32'h8811AABB, 32'h88111234};
        int wc0;
        for (int i = 0; i < 2; i++) begin
            wc0 = wr_count;
            drive(1'b1, 1'b0, 1'b1, f3s[i], adrs[i], wds[i]);
            @(negedge clk);
            checks++; if (lsu_stall !== 1'b1 || dmem_read !== 1'b1 || dmem_write !== 1'b0 || lsu_done !== 1'b0)
                begin failures++; $display("FAIL rmw_c1[%0d] got stall=%b rd=%b wr=%b done=%b exp 1 1 0 0", i, lsu_stall, dmem_read, dmem_write, lsu_done); end
            drive(1'b1, 1'b0, 1'b1, f3s[i], adrs[i], wds[i]);
            @(negedge clk);
            $display("txn RMW f3=%b addr=%h wdata=%h merged=%h", f3s[i], adrs[i], wds[i], dmem_wdata);
            checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || lsu_done !== 1'b1 || lsu_stall !== 1'b0)
                begin failures++; $display("FAIL rmw_c2[%0d] got wr=%b rd=%b done=%b stall=%b exp 1 0 1 0", i, dmem_write, dmem_read, lsu_done, lsu_stall); end
            checks++; if (dmem_wdata !== exps[i]) begin failures++; $display("FAIL rmw_wdata[%0d] got=%h exp=%h", i, dmem_wdata, exps[i]); end
            checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL rmw_addr[%0d] got=%h exp=00000100", i, dmem_addr); end
            drive(1'b0, 1'b0, 1'b0, B, 32'h0, 32'h0);
            @(negedge clk);
            checks++; if (mem[8'h40] !== exps[i]) begin failures++; $display("FAIL rmw_mem[%0d] got=%h exp=%h", i, mem[8'h40], exps[i]); end
            checks++; if (wr_count !== wc0 + 1) begin failures++; $display("FAIL rmw_writes[%0d] got=%0d exp=%0d", i, wr_count - wc0, 1); end
            checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL rmw_done_c3[%0d] got=%b exp=0", i, lsu_done); end
        end
    endtask

    task automatic test_fault();
        logic        lds  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        sts  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s  [5] = '{W, 3'b011, 3'b011, H, W};
        logic [31:0] adrs [5] = '{32'h102, 32'h104, 32'h108, 32'h101, 32'h10C};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, lds[i], sts[i], f3s[i], adrs[i], 32'h5A5A5A5A);
            @(negedge clk);
            $display("txn FAULT ld=%0b st=%0b f3=%b addr=%h flt=%0b cnt=%0d", lds[i], sts[i], f3s[i], adrs[i], lsu_fault, fault_count);
            checks++; if (lsu_fault !== 1'b1 || lsu_done !== 1'b1 || lsu_stall !== 1'b0)
                begin failures++; $display("FAIL fault_flag[%0d] got flt=%b done=%b stall=%b exp 1 1 0", i, lsu_fault, lsu_done, lsu_stall); end
            checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0)
                begin failures++; $display("FAIL fault_noacc[%0d] got rd=%b wr=%b exp 0 0", i, dmem_read, dmem_write); end
            checks++; if (fault_count !== 8'(i)) begin failures++; $display("FAIL fault_cnt[%0d] got=%0d exp=%0d", i, fault_count, i); end
        end
        drive(1'b0, 1'b0, 1'b0, B, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (fault_count !== 8'd5) begin failures++; $display("FAIL fault_cnt_end got=%0d exp=5", fault_count); end
        checks++; if (fault_addr !== 32'h10C) begin failures++; $display("FAIL fault_addr got=%h exp=0000010c", fault_addr); end
    endtask

    task automatic test_valid_low();
        drive(1'b0, 1'b1, 1'b0, W, 32'h100, 32'h12345678);
        @(negedge clk);
        $display("txn IDLE-REQ done=%0b rd=%0b addr=%h", lsu_done, dmem_read, dmem_addr);
        checks++; if ({lsu_done, lsu_stall, lsu_fault, dmem_read, dmem_write} !== 5'b0)
            begin failures++; $display("FAIL novalid_ctrl got=%b exp=00000", {lsu_done, lsu_stall, lsu_fault, dmem_read, dmem_write}); end
        checks++; if (lsu_rdata !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0)
            begin failures++; $display("FAIL novalid_data got rdata=%h addr=%h wdata=%h exp 0", lsu_rdata, dmem_addr, dmem_wdata); end
        checks++; if (fault_count !== 8'd5) begin failures++; $display("FAIL novalid_cnt got=%0d exp=5", fault_count); end
    endtask

    task automatic test_reset_rmw();
        int wc0;
        drive(1'b1, 1'b0, 1'b1, W, 32'h104, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 1'b1, H, 32'h104, 32'h00005555);
        @(negedge clk);
        wc0 = wr_count;
        checks++; if (lsu_stall !== 1'b1) begin failures++; $display("FAIL rstrmw_stall got=%b exp=1", lsu_stall); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        $display("txn SH-with-reset wr=%0b done=%0b", dmem_write, lsu_done);
        checks++; if (dmem_write !== 1'b0 || lsu_done !== 1'b0)
            begin failures++; $display("FAIL rstrmw_nowrite got wr=%b done=%b exp 0 0", dmem_write, lsu_done); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (lsu_stall !== 1'b0 || dmem_write !== 1'b0) begin failures++; $display("FAIL rstrmw_idle got stall=%b wr=%b exp 0 0", lsu_stall, dmem_write); end
        checks++; if (mem[8'h41] !== 32'hCAFEF00D) begin failures++; $display("FAIL rstrmw_mem got=%h exp=cafef00d", mem[8'h41]); end
        checks++; if (wr_count !== wc0) begin failures++; $display("FAIL rstrmw_writes got=%0d exp=0", wr_count - wc0); end
        drive(1'b1, 1'b1, 1'b0, W, 32'h104, 32'h0);
        @(negedge clk);
        checks++; if (lsu_rdata !== 32'hCAFEF00D || lsu_done !== 1'b1 || lsu_stall !== 1'b0)
            begin failures++; $display("FAIL rstrmw_lw got rdata=%h done=%b stall=%b exp cafef00d 1 0", lsu_rdata, lsu_done, lsu_stall); end
        checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL rstrmw_cnt got=%0d exp=0", fault_count); end
    endtask

    task automatic test_saturation();
        logic [31:0] last_addr;
        last_addr = 32'h0;
        for (int i = 0; i < 300; i++) begin
            last_addr = 32'h200 + 32'(4 * i) + 32'h1;
            drive(1'b1, 1'b1, 1'b0, W, last_addr, 32'h0);
            @(negedge clk);
            checks++; if (lsu_fault !== 1'b1) begin failures++; $display("FAIL sat_fault[%0d] got=%b exp=1", i, lsu_fault); end
            if (i == 255) begin
                checks++; if (fault_count !== 8'hFF) begin failures++; $display("FAIL sat_at255 got=%h exp=ff", fault_count); end
            end
        end
        drive(1'b0, 1'b0, 1'b0, B, 32'h0, 32'h0);
        @(negedge clk);
        $display("txn SAT 300 faults cnt=%h faddr=%h", fault_count, fault_addr);
        checks++; if (fault_count !== 8'hFF) begin failures++; $display("FAIL sat_cnt got=%h exp=ff", fault_count); end
        checks++; if (fault_addr !== last_addr) begin failures++; $display("FAIL sat_faddr got=%h exp=%h", fault_addr, last_addr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_store_word();
        test_loads();
        test_rmw();
        test_fault();
        test_valid_low();
        test_reset_rmw();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
